// File: rtl/sdram_req_frontend.sv
// rtl/sdram_req_frontend.sv - command FIFO and single-outstanding request issuer in front of the SDRAM controller
// Read data is held in a response register; a stuck controller is aborted after TIMEOUT cycles.
module sdram_req_frontend #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [24:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  input  logic        ctrl_ready,
  input  logic        ctrl_valid,
  input  logic [15:0] ctrl_data_out,
  output logic        ctrl_read,
  output logic        ctrl_write,
  output logic [24:0] ctrl_address,
  output logic [15:0] ctrl_data_in,
  output logic        busy,
  output logic        err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 42;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

  state_t        state, state_n;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [EW-1:0] head;
  logic          head_we;
  logic [TW-1:0] timer, timer_n;
  logic          timer_done;

  logic          ctrl_read_n, ctrl_write_n;
  logic [24:0]   ctrl_address_n;
  logic [15:0]   ctrl_data_in_n;
  logic          rsp_valid_n;
  logic [15:0]   rsp_data_n;
  logic          err_timeout_n;

  assign cmd_ready  = (count != (AW+1)'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign head_we    = head[41];
  assign timer_done = (timer == TW'(TIMEOUT - 1));
  assign busy       = (count != '0) || (state != IDLE);

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    pop            = 1'b0;
    ctrl_read_n    = ctrl_read;
    ctrl_write_n   = ctrl_write;
    ctrl_address_n = ctrl_address;
    ctrl_data_in_n = ctrl_data_in;
    rsp_valid_n    = rsp_valid;
    rsp_data_n     = rsp_data;
    err_timeout_n  = err_timeout;

    if (rsp_valid && rsp_ready) rsp_valid_n = 1'b0;

    case (state)
      IDLE: begin
        // A read waits until the previous response has been consumed.
        if ((count != '0) && ctrl_ready && (head_we || !rsp_valid)) begin
          ctrl_address_n = head[40:16];
          ctrl_data_in_n = head[15:0];
          ctrl_write_n   = head_we;
          ctrl_read_n    = !head_we;
          pop            = 1'b1;
          timer_n        = '0;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        if (!ctrl_ready) begin
          ctrl_read_n  = 1'b0;
          ctrl_write_n = 1'b0;
          timer_n      = '0;
          state_n      = ctrl_write ? IDLE : WAIT_DATA;
        end else if (timer_done) begin
          err_timeout_n = 1'b1;
          ctrl_read_n   = 1'b0;
          ctrl_write_n  = 1'b0;
          timer_n       = '0;
          state_n       = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_DATA: begin
        if (ctrl_valid) begin
          rsp_data_n  = ctrl_data_out;
          rsp_valid_n = 1'b1;
          timer_n     = '0;
          state_n     = IDLE;
        end else if (timer_done) begin
          err_timeout_n = 1'b1;
          timer_n       = '0;
          state_n       = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      ctrl_read    <= 1'b0;
      ctrl_write   <= 1'b0;
      ctrl_address <= '0;
      ctrl_data_in <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      ctrl_read    <= ctrl_read_n;
      ctrl_write   <= ctrl_write_n;
      ctrl_address <= ctrl_address_n;
      ctrl_data_in <= ctrl_data_in_n;
      rsp_valid    <= rsp_valid_n;
      rsp_data     <= rsp_data_n;
      err_timeout  <= err_timeout_n;
    end
  end

endmodule

// File: tb/tb_sdram_req_frontend.sv
// tb/tb_sdram_req_frontend.sv - directed scoreboard bench for sdram_req_frontend
module tb_sdram_req_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [24:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        ctrl_ready, ctrl_valid;
  logic [15:0] ctrl_data_out;
  logic        ctrl_read, ctrl_write;
  logic [24:0] ctrl_address;
  logic [15:0] ctrl_data_in;
  logic        busy, err_timeout;

  always #5 clk = ~clk;

  sdram_req_frontend #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ctrl_ready(ctrl_ready), .ctrl_valid(ctrl_valid), .ctrl_data_out(ctrl_data_out),
    .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
    .ctrl_address(ctrl_address), .ctrl_data_in(ctrl_data_in),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  int          checks = 0;
  int          errors = 0;
  cmd_t        exp_cmd[$];
  logic [15:0] exp_rsp[$];
  int          wr_pulses = 0, rd_pulses = 0;
  int          cyc = 0, wr_rise_cyc = 0, rd_rise_cyc = 0;
  logic        prev_w = 1'b0, prev_r = 1'b0;
  cmd_t        mon_e;

  logic        m_hold_low = 1'b0, m_never_drop = 1'b0, m_no_valid = 1'b0;
  int          rec = 0, rd_cnt = 0;
  logic [24:0] rd_addr = '0;
  logic [15:0] mmem [logic [24:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Controller model: accepts by dropping ready, recovers after 2 cycles, returns read data 4 cycles after acceptance.
  always @(negedge clk) begin
    if (reset) begin
      ctrl_ready = 1'b1;
      ctrl_valid = 1'b0;
      rec        = 0;
      rd_cnt     = 0;
    end else begin
      ctrl_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0 && !m_no_valid) begin
          ctrl_valid    = 1'b1;
          ctrl_data_out = mmem.exists(rd_addr) ? mmem[rd_addr] : 16'h0;
        end
      end
      if (rec > 0) rec--;
      if (m_hold_low) begin
        ctrl_ready = 1'b0;
      end else if (ctrl_ready && (ctrl_write || ctrl_read) && !m_never_drop) begin
        if (ctrl_write) mmem[ctrl_address] = ctrl_data_in;
        else begin
          rd_addr = ctrl_address;
          rd_cnt  = 4;
        end
        ctrl_ready = 1'b0;
        rec        = 2;
      end else if (rec == 0) begin
        ctrl_ready = 1'b1;
      end
    end
  end

  // Issue monitor: every new ctrl pulse is matched against the command scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_w = 1'b0;
      prev_r = 1'b0;
    end else begin
      if ((ctrl_write && !prev_w) || (ctrl_read && !prev_r)) begin
        if (ctrl_write && !prev_w) begin wr_pulses++; wr_rise_cyc = cyc; end
        if (ctrl_read && !prev_r)  begin rd_pulses++; rd_rise_cyc = cyc; end
        chk("issue_exclusive", {63'b0, ctrl_write & ctrl_read}, 64'd0);
        chk("issue_expected", {63'b0, exp_cmd.size() != 0}, 64'd1);
        if (exp_cmd.size() != 0) begin
          mon_e = exp_cmd.pop_front();
          chk("issue_we", {63'b0, ctrl_write}, {63'b0, mon_e.we});
          chk("issue_addr", {39'b0, ctrl_address}, {39'b0, mon_e.addr});
          if (mon_e.we) chk("issue_wdata", {48'b0, ctrl_data_in}, {48'b0, mon_e.wdata});
        end
      end
      prev_w = ctrl_write;
      prev_r = ctrl_read;
    end
  end

  task automatic push_cmd(input logic we, input logic [24:0] addr, input logic [15:0] wd,
                          input logic exp_acc, input string tag);
    logic acc;
    cmd_t c;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    acc       = cmd_ready;
    @(posedge clk);
    if (acc) begin
      c.we = we; c.addr = addr; c.wdata = wd;
      exp_cmd.push_back(c);
    end
    step();
    cmd_valid = 1'b0;
    chk(tag, {63'b0, acc}, {63'b0, exp_acc});
  endtask

  task automatic wait_rsp(input int maxc, input string tag);
    int n = 0;
    while (!rsp_valid && n < maxc) begin step(); n++; end
    chk(tag, {63'b0, rsp_valid}, 64'd1);
  endtask

  task automatic check_rsp(input string tag);
    logic [15:0] e;
    chk({tag, "_queued"}, {63'b0, exp_rsp.size() != 0}, 64'd1);
    if (exp_rsp.size() != 0) begin
      e = exp_rsp.pop_front();
      chk(tag, {48'b0, rsp_data}, {48'b0, e});
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin step(); n++; end
    chk(tag, {63'b0, busy}, 64'd0);
  endtask

  task automatic wait_wr(input int target, input int maxc, input string tag);
    int n = 0;
    while (wr_pulses < target && n < maxc) begin step(); n++; end
    chk(tag, wr_pulses, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, n, err_cyc, fall_cyc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; ctrl_ready = 1'b1; ctrl_valid = 1'b0; ctrl_data_out = '0;
    repeat (3) step();
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {48'b0, rsp_data}, 64'd0);
    chk("rst_ctrl_rw", {62'b0, ctrl_read, ctrl_write}, 64'd0);
    chk("rst_ctrl_addr", {39'b0, ctrl_address}, 64'd0);
    chk("rst_ctrl_din", {48'b0, ctrl_data_in}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_err", {63'b0, err_timeout}, 64'd0);
    reset = 1'b0;
    step();

    // Write then read back
    push_cmd(1'b1, 25'h0000400, 16'hA5A5, 1'b1, "t1_push_wr");
    push_cmd(1'b0, 25'h0000400, 16'h0000, 1'b1, "t1_push_rd");
    exp_rsp.push_back(16'hA5A5);
    wait_rsp(100, "t1_rsp_wait");
    check_rsp("t1_rsp_data");
    repeat (5) step();
    chk("t1_rsp_hold", {63'b0, rsp_valid}, 64'd1);
    consume();
    chk("t1_rsp_clear", {63'b0, rsp_valid}, 64'd0);
    chk("t1_wr_pulses", wr_pulses, 1);
    chk("t1_rd_pulses", rd_pulses, 1);
    wait_idle(50, "t1_idle");

    // FIFO full while the controller is held not-ready
    m_hold_low = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) push_cmd(1'b1, 25'(i), 16'(16'h1000 + i), 1'b1, "t2_push");
    chk("t2_full", {63'b0, cmd_ready}, 64'd0);
    push_cmd(1'b1, 25'h1FF, 16'hDEAD, 1'b0, "t2_push9_refused");
    chk("t2_busy", {63'b0, busy}, 64'd1);
    chk("t2_no_issue", wr_pulses, 1);
    m_hold_low = 1'b0;
    wait_wr(9, 300, "t2_wr_pulses");
    wait_idle(50, "t2_idle");
    chk("t2_queue_drained", exp_cmd.size(), 0);

    // Response backpressure stalls the second read
    push_cmd(1'b0, 25'd3, 16'h0, 1'b1, "t3_push_a");
    push_cmd(1'b0, 25'd5, 16'h0, 1'b1, "t3_push_b");
    exp_rsp.push_back(16'h1003);
    exp_rsp.push_back(16'h1005);
    wait_rsp(100, "t3_rsp_a_wait");
    check_rsp("t3_rsp_a_data");
    repeat (20) step();
    chk("t3_stall", rd_pulses, 2);
    chk("t3_hold_data", {48'b0, rsp_data}, 64'h1003);
    consume();
    chk("t3_rsp_a_clear", {63'b0, rsp_valid}, 64'd0);
    wait_rsp(100, "t3_rsp_b_wait");
    check_rsp("t3_rsp_b_data");
    chk("t3_rd_pulses", rd_pulses, 3);
    consume();
    wait_idle(50, "t3_idle");

    // Timeout in WAIT_DATA, then the queued write still issues
    m_no_valid = 1'b1;
    w0 = wr_pulses;
    push_cmd(1'b0, 25'h10, 16'h0, 1'b1, "t4_push_rd");
    push_cmd(1'b1, 25'h20, 16'hBEEF, 1'b1, "t4_push_wr");
    n = 0;
    while (!err_timeout && n < 200) begin step(); n++; end
    err_cyc = cyc;
    chk("t4_err_set", {63'b0, err_timeout}, 64'd1);
    chk("t4_latency", err_cyc - rd_rise_cyc, 65);
    chk("t4_no_rsp", {63'b0, rsp_valid}, 64'd0);
    wait_wr(w0 + 1, 50, "t4_write_after");
    wait_idle(50, "t4_idle");
    chk("t4_err_sticky", {63'b0, err_timeout}, 64'd1);
    m_no_valid = 1'b0;

    reset = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    step(); step();
    reset = 1'b0;
    step();
    chk("t5_err_cleared", {63'b0, err_timeout}, 64'd0);

    // Timeout in ISSUE: controller never drops ready
    m_never_drop = 1'b1;
    w0 = wr_pulses;
    push_cmd(1'b1, 25'h30, 16'h1234, 1'b1, "t5_push");
    wait_wr(w0 + 1, 20, "t5_issued");
    n = 0;
    while (ctrl_write && n < 200) begin step(); n++; end
    fall_cyc = cyc;
    chk("t5_write_fell", {63'b0, ctrl_write}, 64'd0);
    chk("t5_latency", fall_cyc - wr_rise_cyc, 64);
    chk("t5_err_set", {63'b0, err_timeout}, 64'd1);
    m_never_drop = 1'b0;
    wait_idle(20, "t5_idle");

    // Asynchronous reset while waiting for read data with 3 commands queued
    m_no_valid = 1'b1;
    push_cmd(1'b0, 25'h40, 16'h7777, 1'b1, "t6_push_rd");
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 25'(25'h50 + i), 16'(16'h2000 + i), 1'b1, "t6_push_wr");
    repeat (5) step();
    chk("t6_busy", {63'b0, busy}, 64'd1);
    chk("t6_addr_held", {39'b0, ctrl_address}, 64'h40);
    chk("t6_din_held", {48'b0, ctrl_data_in}, 64'h7777);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    chk("t6_rst_busy", {63'b0, busy}, 64'd0);
    chk("t6_rst_ctrl_rw", {62'b0, ctrl_read, ctrl_write}, 64'd0);
    chk("t6_rst_addr", {39'b0, ctrl_address}, 64'd0);
    chk("t6_rst_din", {48'b0, ctrl_data_in}, 64'd0);
    chk("t6_rst_err", {63'b0, err_timeout}, 64'd0);
    chk("t6_rst_rsp", {63'b0, rsp_valid}, 64'd0);
    exp_cmd.delete();
    exp_rsp.delete();
    m_no_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    repeat (30) step();
    chk("t6_no_wr_after", wr_pulses, w0);
    chk("t6_no_rd_after", rd_pulses, r0);
    chk("t6_busy_after", {63'b0, busy}, 64'd0);
    chk("end_rsp_queue", exp_rsp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
